output_vc_tracker: RTL and testbench
====================================

Name: output_vc_tracker

Overview:
- Per-output-port tracker of virtual-channel (VC) ownership and downstream buffer credits for NUM_VC VCs.
- Sits in the output stage of each router port, between the VC allocator (claims a free VC) and the switch traversal (flits fired downstream).
- Generalises the single-VC available flag with:
  - a per-VC state machine;
  - credit counters;
  - an atomic-VC mode, where a VC is released only after the downstream buffer drains.

Parameters:
- NUM_VC, 4, number of VCs on this output port (>=1).
- BUF_DEPTH, 4, downstream input-buffer depth per VC, in flits (>=1). Credit counters reset to this value.
- CW, $clog2(BUF_DEPTH+1), credit counter width. Derived, not overridden.
- ATOMIC_VC, 0, release mode. 0 = release on tail fire. 1 = release only when tail has fired and credits are back at BUF_DEPTH.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- flit_fire  in  1  a flit leaves on this output this cycle.
- flit_vc  in  NUM_VC  one-hot VC of the fired flit.
- flit_type  in  2  type of the fired flit: HEAD/BODY/TAIL/SINGLE encodings from params.vh. SINGLE counts as tail.
- alloc_valid  in  1  VC allocator claims a VC this cycle.
- alloc_vc  in  NUM_VC  one-hot VC being claimed.
- credit_valid  in  1  downstream returns one credit.
- credit_vc  in  NUM_VC  one-hot VC of the returned credit.
- out_vc_available  out  NUM_VC  VC is IDLE and claimable.
- out_vc_credit_ok  out  NUM_VC  VC credit count > 0.
- credit_count  out  NUM_VC*CW  packed credit counters; VC i at [i*CW +: CW].
- err  out  1  sticky protocol error.

Behaviour:
- Reset (rst=1 at a clk edge), from any state, including mid-packet:
  - all VCs -> IDLE;
  - credits = BUF_DEPTH;
  - out_vc_available = all ones;
  - out_vc_credit_ok = all ones;
  - err = 0.
  - Reset overrides every concurrent input.
- Per-VC FSM states:
  - IDLE: available = 1.
  - ACTIVE: claimed, packet in flight.
  - DRAIN: tail sent, awaiting credits. Reachable only when ATOMIC_VC = 1.
- FSM transitions. "Tail fire" means flit_fire with the VC selected and flit_type = TAIL or SINGLE.
  - IDLE -> ACTIVE on alloc_valid with the VC selected.
  - ACTIVE -> IDLE on tail fire, when ATOMIC_VC = 0.
  - ACTIVE -> DRAIN on tail fire, when ATOMIC_VC = 1 and the post-update credit < BUF_DEPTH.
  - ACTIVE -> IDLE on tail fire, when ATOMIC_VC = 1 and the post-update credit = BUF_DEPTH. Only possible if a credit returns in the same cycle with BUF_DEPTH = 1 net.
  - DRAIN -> IDLE in the cycle the post-update credit reaches BUF_DEPTH.
- Simultaneous claim and tail fire on the same ACTIVE VC: the tail wins; next state follows the tail rules. The claim is an error (the VC was not available).
- Claim on a non-IDLE VC: state unchanged; err set.
- Output timing: all outputs are registered and reflect state after the edge. A freed VC shows available = 1 on the cycle after the tail fire (ATOMIC_VC = 0).
- Credit arithmetic, per VC, per cycle:
  - next = cnt - fire_i + ret_i;
  - fire and return together -> unchanged;
  - counters saturate: never below 0, never above BUF_DEPTH.
- Credit errors:
  - fire on a VC with credit 0 -> err, counter stays 0;
  - return on a VC at BUF_DEPTH -> err, counter stays BUF_DEPTH.
- Other errors (each sets err):
  - flit fire on an IDLE VC; no state or credit change except the decrement;
  - flit_vc or alloc_vc or credit_vc not one-hot while the matching valid is high; that event is ignored.
- err is cleared only by rst.
- out_vc_credit_ok[i] = (credit_count[i] != 0), registered alongside the counter.
- Zero-latency rule: no combinational path from any input to any output.

Test Plan:
- Reset then idle, NUM_VC=4, BUF_DEPTH=4 -> available=4'b1111, credit_ok=4'b1111, every credit_count=4, err=0.
- Claim VC2, fire HEAD/BODY/TAIL on VC2, ATOMIC_VC=0 -> VC2 available=0 from cycle after claim; credits 3,2,1; available=1 the cycle after TAIL; no credits returned yet.
- Same sequence with ATOMIC_VC=1 -> after TAIL, VC2 in DRAIN, available=0; return 3 credits -> available=1 the cycle after credit_count reaches 4.
- Fire 4 flits on VC0 with no returns, then a 5th -> credit_count 0, credit_ok[0]=0, err=1 on the 5th; fire+return in the same cycle at credit 2 -> stays 2.
- Claim VC1 while ACTIVE -> state unchanged, err=1; assert rst mid-packet -> all VCs IDLE, credits 4, err=0 next cycle.
- Claim VC3 and tail-fire VC3 in the same cycle (VC3 ACTIVE, ATOMIC_VC=0) -> VC3 IDLE next cycle, err=1.

Source files
------------

// File: rtl/output_vc_tracker.sv
// Output-port VC tracker: per-VC ownership FSM (IDLE/ACTIVE/DRAIN) plus saturating
// downstream credit counters, with an optional atomic mode that holds a VC until its buffer drains.
module output_vc_tracker #(
  parameter int NUM_VC    = 4,
  parameter int BUF_DEPTH = 4,
  parameter int ATOMIC_VC = 0,
  localparam int CW       = $clog2(BUF_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flit_fire,
  input  logic [NUM_VC-1:0]    flit_vc,
  input  logic [1:0]           flit_type,
  input  logic                 alloc_valid,
  input  logic [NUM_VC-1:0]    alloc_vc,
  input  logic                 credit_valid,
  input  logic [NUM_VC-1:0]    credit_vc,
  output logic [NUM_VC-1:0]    out_vc_available,
  output logic [NUM_VC-1:0]    out_vc_credit_ok,
  output logic [NUM_VC*CW-1:0] credit_count,
  output logic                 err
);

  // Flit type encodings: HEAD=00, BODY=01, TAIL=10, SINGLE=11.
  localparam logic [1:0] FT_TAIL   = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;

  localparam logic [CW-1:0] CRED_FULL = CW'(BUF_DEPTH);
  localparam logic [CW-1:0] CRED_ONE  = CW'(1);

  logic [1:0]        state_q  [NUM_VC];
  logic [1:0]        state_d  [NUM_VC];
  logic [CW-1:0]     credit_q [NUM_VC];
  logic [CW-1:0]     credit_d [NUM_VC];
  logic [NUM_VC-1:0] avail_q, avail_d;
  logic [NUM_VC-1:0] ok_q, ok_d;
  logic              err_q, err_d;

  logic              fire_ok, alloc_ok, credit_ok;
  logic              is_tail;
  logic [NUM_VC-1:0] fire_vec, alloc_vec, ret_vec;

  // Events with a malformed VC select are dropped entirely; only err records them.
  always_comb begin
    fire_ok   = flit_fire && $onehot(flit_vc);
    alloc_ok  = alloc_valid && $onehot(alloc_vc);
    credit_ok = credit_valid && $onehot(credit_vc);
    fire_vec  = fire_ok   ? flit_vc   : '0;
    alloc_vec = alloc_ok  ? alloc_vc  : '0;
    ret_vec   = credit_ok ? credit_vc : '0;
    is_tail   = (flit_type == FT_TAIL) || (flit_type == FT_SINGLE);
  end

  always_comb begin
    err_d   = err_q;
    avail_d = '0;
    ok_d    = '0;
    if (flit_fire && !fire_ok)       err_d = 1'b1;
    if (alloc_valid && !alloc_ok)    err_d = 1'b1;
    if (credit_valid && !credit_ok)  err_d = 1'b1;

    for (int i = 0; i < NUM_VC; i++) begin
      credit_d[i] = credit_q[i];
      state_d[i]  = state_q[i];

      // A fire and a return in the same cycle cancel, so saturation checks apply only to lone events.
      if (fire_vec[i] && !ret_vec[i]) begin
        if (credit_q[i] == '0) err_d = 1'b1;
        else                   credit_d[i] = credit_q[i] - CRED_ONE;
      end else if (ret_vec[i] && !fire_vec[i]) begin
        if (credit_q[i] == CRED_FULL) err_d = 1'b1;
        else                          credit_d[i] = credit_q[i] + CRED_ONE;
      end

      case (state_q[i])
        ST_IDLE: begin
          if (fire_vec[i])  err_d = 1'b1;
          if (alloc_vec[i]) state_d[i] = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (alloc_vec[i]) err_d = 1'b1;
          // A tail beats a concurrent claim; atomic mode waits for the post-update credit to be full.
          if (fire_vec[i] && is_tail) begin
            if ((ATOMIC_VC == 0) || (credit_d[i] == CRED_FULL)) state_d[i] = ST_IDLE;
            else                                               state_d[i] = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (alloc_vec[i])               err_d = 1'b1;
          if (credit_d[i] == CRED_FULL)   state_d[i] = ST_IDLE;
        end
        default: state_d[i] = ST_IDLE;
      endcase

      avail_d[i] = (state_d[i] == ST_IDLE);
      ok_d[i]    = (credit_d[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_VC; i++) begin
        state_q[i]  <= ST_IDLE;
        credit_q[i] <= CRED_FULL;
      end
      avail_q <= '1;
      ok_q    <= '1;
      err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_VC; i++) begin
        state_q[i]  <= state_d[i];
        credit_q[i] <= credit_d[i];
      end
      avail_q <= avail_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  for (genvar g = 0; g < NUM_VC; g++) begin : g_pack
    assign credit_count[g*CW +: CW] = credit_q[g];
  end

  assign out_vc_available = avail_q;
  assign out_vc_credit_ok = ok_q;
  assign err              = err_q;

endmodule

// File: tb/tb_output_vc_tracker.sv
// Bench for output_vc_tracker: one release-on-tail instance and one atomic instance share stimulus;
// each vector names which instance it checks and carries hand-derived expected outputs.
module tb_output_vc_tracker;

  localparam int NUM_VC = 4;
  localparam int CW     = 3;
  localparam logic [1:0] FH = 2'b00;
  localparam logic [1:0] FB = 2'b01;
  localparam logic [1:0] FT = 2'b10;
  localparam logic [1:0] FS = 2'b11;

  logic clk = 1'b0;
  logic rst, flit_fire, alloc_valid, credit_valid;
  logic [NUM_VC-1:0] flit_vc, alloc_vc, credit_vc;
  logic [1:0] flit_type;
  logic [NUM_VC-1:0] av0, ok0, av1, ok1;
  logic [NUM_VC*CW-1:0] cnt0, cnt1;
  logic err0, err1;

  always #5 clk = ~clk;

  output_vc_tracker #(.NUM_VC(4), .BUF_DEPTH(4), .ATOMIC_VC(0)) dut0 (
    .clk(clk), .rst(rst), .flit_fire(flit_fire), .flit_vc(flit_vc), .flit_type(flit_type),
    .alloc_valid(alloc_valid), .alloc_vc(alloc_vc), .credit_valid(credit_valid), .credit_vc(credit_vc),
    .out_vc_available(av0), .out_vc_credit_ok(ok0), .credit_count(cnt0), .err(err0));

  output_vc_tracker #(.NUM_VC(4), .BUF_DEPTH(4), .ATOMIC_VC(1)) dut1 (
    .clk(clk), .rst(rst), .flit_fire(flit_fire), .flit_vc(flit_vc), .flit_type(flit_type),
    .alloc_valid(alloc_valid), .alloc_vc(alloc_vc), .credit_valid(credit_valid), .credit_vc(credit_vc),
    .out_vc_available(av1), .out_vc_credit_ok(ok1), .credit_count(cnt1), .err(err1));

  typedef struct packed {
    logic        sel;
    logic        rst;
    logic        fire;
    logic [3:0]  fvc;
    logic [1:0]  ft;
    logic        alloc;
    logic [3:0]  avc;
    logic        cred;
    logic [3:0]  cvc;
    logic [3:0]  e_avail;
    logic [3:0]  e_ok;
    logic [11:0] e_cnt;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];
  logic [21:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int vec_idx = 0;

  function automatic logic [11:0] c4(input int c3, input int c2, input int c1, input int c0);
    return {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
  endfunction

  function automatic vec_t mk(input logic sel, input logic r, input logic fire, input logic [3:0] fvc,
                              input logic [1:0] ft, input logic alloc, input logic [3:0] avc,
                              input logic cred, input logic [3:0] cvc, input logic [3:0] ea,
                              input logic [3:0] eo, input logic [11:0] ec, input logic ee);
    vec_t v;
    v.sel = sel; v.rst = r; v.fire = fire; v.fvc = fvc; v.ft = ft; v.alloc = alloc; v.avc = avc;
    v.cred = cred; v.cvc = cvc; v.e_avail = ea; v.e_ok = eo; v.e_cnt = ec; v.e_err = ee;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    @(negedge clk);
    rst = v.rst; flit_fire = v.fire; flit_vc = v.fvc; flit_type = v.ft;
    alloc_valid = v.alloc; alloc_vc = v.avc; credit_valid = v.cred; credit_vc = v.cvc;
    exp_q.push_back({v.sel, v.e_avail, v.e_ok, v.e_cnt, v.e_err});
  endtask

  task automatic check_out();
    logic [21:0] e;
    logic [20:0] obs;
    e   = exp_q.pop_front();
    obs = e[21] ? {av1, ok1, cnt1, err1} : {av0, ok0, cnt0, err0};
    checks++;
    if (obs !== e[20:0]) begin
      errors++;
      $display("FAIL vec%0d dut%0d: got avail=%b ok=%b cnt=%h err=%b, expected avail=%b ok=%b cnt=%h err=%b",
               vec_idx, e[21], obs[20:17], obs[16:13], obs[12:1], obs[0],
               e[20:17], e[16:13], e[12:1], e[0]);
    end
  endtask

  initial begin
    rst = 1'b1; flit_fire = 1'b0; flit_vc = '0; flit_type = FH;
    alloc_valid = 1'b0; alloc_vc = '0; credit_valid = 1'b0; credit_vc = '0;

    // Release-on-tail instance: claim / HEAD-BODY-TAIL / credit return.
    vecs.push_back(mk(0, 1, 0, 4'h0, FH, 0, 4'h0, 0, 4'h0, 4'hF, 4'hF, c4(4,4,4,4), 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, FH, 0, 4'h0, 0, 4'h0, 4'hF, 4'hF, c4(4,4,4,4), 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, FH, 1, 4'h4, 0, 4'h0, 4'hB, 4'hF, c4(4,4,4,4), 0));
    vecs.push_back(mk(0, 0, 1, 4'h4, FH, 0, 4'h0, 0, 4'h0, 4'hB, 4'hF, c4(4,3,4,4), 0));
    vecs.push_back(mk(0, 0, 1, 4'h4, FB, 0, 4'h0, 0, 4'h0, 4'hB, 4'hF, c4(4,2,4,4), 0));
    vecs.push_back(mk(0, 0, 1, 4'h4, FT, 0, 4'h0, 0, 4'h0, 4'hF, 4'hF, c4(4,1,4,4), 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, FH, 0, 4'h0, 0, 4'h0, 4'hF, 4'hF, c4(4,1,4,4), 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, FH, 0, 4'h0, 1, 4'h4, 4'hF, 4'hF, c4(4,2,4,4), 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, FH, 0, 4'h0, 1, 4'h4, 4'hF, 4'hF, c4(4,3,4,4), 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, FH, 0, 4'h0, 1, 4'h4, 4'hF, 4'hF, c4(4,4,4,4), 0));
    // Exhaust VC0 credits, then underflow.
    vecs.push_back(mk(0, 0, 0, 4'h0, FH, 1, 4'h1, 0, 4'h0, 4'hE, 4'hF, c4(4,4,4,4), 0));
    vecs.push_back(mk(0, 0, 1, 4'h1, FB, 0, 4'h0, 0, 4'h0, 4'hE, 4'hF, c4(4,4,4,3), 0));
    vecs.push_back(mk(0, 0, 1, 4'h1, FB, 0, 4'h0, 0, 4'h0, 4'hE, 4'hF, c4(4,4,4,2), 0));
    vecs.push_back(mk(0, 0, 1, 4'h1, FB, 0, 4'h0, 0, 4'h0, 4'hE, 4'hF, c4(4,4,4,1), 0));
    vecs.push_back(mk(0, 0, 1, 4'h1, FB, 0, 4'h0, 0, 4'h0, 4'hE, 4'hE, c4(4,4,4,0), 0));
    vecs.push_back(mk(0, 0, 1, 4'h1, FB, 0, 4'h0, 0, 4'h0, 4'hE, 4'hE, c4(4,4,4,0), 1));
    // Fire and return together hold the count.
    vecs.push_back(mk(0, 1, 0, 4'h0, FH, 0, 4'h0, 0, 4'h0, 4'hF, 4'hF, c4(4,4,4,4), 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, FH, 1, 4'h1, 0, 4'h0, 4'hE, 4'hF, c4(4,4,4,4), 0));
    vecs.push_back(mk(0, 0, 1, 4'h1, FH, 0, 4'h0, 0, 4'h0, 4'hE, 4'hF, c4(4,4,4,3), 0));
    vecs.push_back(mk(0, 0, 1, 4'h1, FB, 0, 4'h0, 0, 4'h0, 4'hE, 4'hF, c4(4,4,4,2), 0));
    vecs.push_back(mk(0, 0, 1, 4'h1, FB, 0, 4'h0, 1, 4'h1, 4'hE, 4'hF, c4(4,4,4,2), 0));
    vecs.push_back(mk(0, 0, 1, 4'h1, FT, 0, 4'h0, 1, 4'h1, 4'hF, 4'hF, c4(4,4,4,2), 0));
    // Claim of an ACTIVE VC, then reset mid-packet with concurrent inputs.
    vecs.push_back(mk(0, 0, 0, 4'h0, FH, 1, 4'h2, 0, 4'h0, 4'hD, 4'hF, c4(4,4,4,2), 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, FH, 1, 4'h2, 0, 4'h0, 4'hD, 4'hF, c4(4,4,4,2), 1));
    vecs.push_back(mk(0, 0, 1, 4'h2, FH, 0, 4'h0, 0, 4'h0, 4'hD, 4'hF, c4(4,4,3,2), 1));
    vecs.push_back(mk(0, 1, 1, 4'h2, FT, 1, 4'h8, 1, 4'h1, 4'hF, 4'hF, c4(4,4,4,4), 0));
    // Claim and tail on the same ACTIVE VC.
    vecs.push_back(mk(0, 0, 0, 4'h0, FH, 1, 4'h8, 0, 4'h0, 4'h7, 4'hF, c4(4,4,4,4), 0));
    vecs.push_back(mk(0, 0, 1, 4'h8, FT, 1, 4'h8, 0, 4'h0, 4'hF, 4'hF, c4(3,4,4,4), 1));
    // Fire on IDLE, bad one-hot selects, return at full.
    vecs.push_back(mk(0, 1, 0, 4'h0, FH, 0, 4'h0, 0, 4'h0, 4'hF, 4'hF, c4(4,4,4,4), 0));
    vecs.push_back(mk(0, 0, 1, 4'h2, FS, 0, 4'h0, 0, 4'h0, 4'hF, 4'hF, c4(4,4,3,4), 1));
    vecs.push_back(mk(0, 1, 0, 4'h0, FH, 0, 4'h0, 0, 4'h0, 4'hF, 4'hF, c4(4,4,4,4), 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, FH, 1, 4'h3, 0, 4'h0, 4'hF, 4'hF, c4(4,4,4,4), 1));
    vecs.push_back(mk(0, 1, 0, 4'h0, FH, 0, 4'h0, 0, 4'h0, 4'hF, 4'hF, c4(4,4,4,4), 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, FH, 0, 4'h0, 1, 4'h1, 4'hF, 4'hF, c4(4,4,4,4), 1));
    vecs.push_back(mk(0, 1, 0, 4'h0, FH, 0, 4'h0, 0, 4'h0, 4'hF, 4'hF, c4(4,4,4,4), 0));
    vecs.push_back(mk(0, 0, 1, 4'hC, FB, 0, 4'h0, 0, 4'h0, 4'hF, 4'hF, c4(4,4,4,4), 1));
    vecs.push_back(mk(0, 1, 0, 4'h0, FH, 0, 4'h0, 0, 4'h0, 4'hF, 4'hF, c4(4,4,4,4), 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, FH, 0, 4'h0, 1, 4'h0, 4'hF, 4'hF, c4(4,4,4,4), 1));

    foreach (vecs[i]) begin
      vec_idx = i;
      drive(vecs[i]);
      @(posedge clk); #1;
      check_out();
    end

    // Atomic instance: DRAIN hold, claim during DRAIN, tail with net-zero credit change.
    vecs.delete();
    vecs.push_back(mk(1, 1, 0, 4'h0, FH, 0, 4'h0, 0, 4'h0, 4'hF, 4'hF, c4(4,4,4,4), 0));
    vecs.push_back(mk(1, 0, 0, 4'h0, FH, 1, 4'h4, 0, 4'h0, 4'hB, 4'hF, c4(4,4,4,4), 0));
    vecs.push_back(mk(1, 0, 1, 4'h4, FH, 0, 4'h0, 0, 4'h0, 4'hB, 4'hF, c4(4,3,4,4), 0));
    vecs.push_back(mk(1, 0, 1, 4'h4, FB, 0, 4'h0, 0, 4'h0, 4'hB, 4'hF, c4(4,2,4,4), 0));
    vecs.push_back(mk(1, 0, 1, 4'h4, FT, 0, 4'h0, 0, 4'h0, 4'hB, 4'hF, c4(4,1,4,4), 0));
    vecs.push_back(mk(1, 0, 0, 4'h0, FH, 0, 4'h0, 1, 4'h4, 4'hB, 4'hF, c4(4,2,4,4), 0));
    vecs.push_back(mk(1, 0, 0, 4'h0, FH, 0, 4'h0, 1, 4'h4, 4'hB, 4'hF, c4(4,3,4,4), 0));
    vecs.push_back(mk(1, 0, 0, 4'h0, FH, 0, 4'h0, 1, 4'h4, 4'hF, 4'hF, c4(4,4,4,4), 0));
    vecs.push_back(mk(1, 0, 0, 4'h0, FH, 1, 4'h4, 0, 4'h0, 4'hB, 4'hF, c4(4,4,4,4), 0));
    vecs.push_back(mk(1, 0, 1, 4'h4, FS, 0, 4'h0, 0, 4'h0, 4'hB, 4'hF, c4(4,3,4,4), 0));
    vecs.push_back(mk(1, 0, 0, 4'h0, FH, 1, 4'h4, 0, 4'h0, 4'hB, 4'hF, c4(4,3,4,4), 1));
    vecs.push_back(mk(1, 0, 0, 4'h0, FH, 0, 4'h0, 1, 4'h4, 4'hF, 4'hF, c4(4,4,4,4), 1));
    vecs.push_back(mk(1, 1, 0, 4'h0, FH, 0, 4'h0, 0, 4'h0, 4'hF, 4'hF, c4(4,4,4,4), 0));
    vecs.push_back(mk(1, 0, 0, 4'h0, FH, 1, 4'h2, 0, 4'h0, 4'hD, 4'hF, c4(4,4,4,4), 0));
    vecs.push_back(mk(1, 0, 1, 4'h2, FS, 0, 4'h0, 1, 4'h2, 4'hF, 4'hF, c4(4,4,4,4), 0));

    foreach (vecs[i]) begin
      vec_idx = 100 + i;
      drive(vecs[i]);
      @(posedge clk); #1;
      check_out();
    end

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
